// File: rtl/n64_pkg.sv
// Shared definitions for the N64 controller one-wire bus: decoder state
// encoding and default 50 MHz bit-cell timing constants.
package n64_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    MEAS_LOW  = 2'd2,
    MEAS_HIGH = 2'd3
  } n64_state_e;

  localparam int N64_NBITS   = 32;
  localparam int N64_THRESH  = 100;
  localparam int N64_LOW_MAX = 250;
  localparam int N64_IDLE_TO = 300;

  function automatic int n64_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/n64_bit_decoder_if.sv
// Bus-side and frame-side signals of the N64 bit decoder; the decoder is the
// slave, the environment (line driver / arm source) is the master.
interface n64_bit_decoder_if;
  logic din;
  logic arm;
  logic serout;
  logic shift_en;
  logic busy;
  logic frame_done;
  logic frame_err;

  modport master (
    output din, arm,
    input  serout, shift_en, busy, frame_done, frame_err
  );

  modport slave (
    input  din, arm,
    output serout, shift_en, busy, frame_done, frame_err
  );
endinterface

// File: rtl/n64_sync.sv
// Two-flop synchronizer for the open-drain line (idles high) with registered
// fall/rise strobes aligned to the synchronized level.
module n64_sync (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic cur,
  output logic fall,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic fall_q, fall_d;
  logic rise_q, rise_d;

  // Edge strobes compare the level about to enter s2 with the one leaving it,
  // so they line up with the new value of cur.
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    fall_d = s2_q & ~s1_q;
    rise_d = ~s2_q & s1_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      fall_q <= fall_d;
      rise_q <= rise_d;
    end
  end

  assign cur  = s2_q;
  assign fall = fall_q;
  assign rise = rise_q;

endmodule

// File: rtl/n64_bit_decoder.sv
// Receive-side N64 line decoder: measures each bit cell's low time, emits a
// serial bit plus shift strobe per data bit, and delimits the response frame.
module n64_bit_decoder
  import n64_pkg::*;
#(
  parameter int NBITS   = N64_NBITS,
  parameter int THRESH  = N64_THRESH,
  parameter int LOW_MAX = N64_LOW_MAX,
  parameter int IDLE_TO = N64_IDLE_TO
) (
  input logic              clk,
  input logic              rstn,
  n64_bit_decoder_if.slave bus
);

  localparam int CNT_W  = $clog2(n64_max(LOW_MAX, IDLE_TO)) + 1;
  localparam int BCNT_W = $clog2(NBITS + 1);

  localparam logic [CNT_W-1:0]  THRESH_C  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0]  LOW_MAX_C = CNT_W'(LOW_MAX);
  localparam logic [CNT_W-1:0]  IDLE_TO_C = CNT_W'(IDLE_TO);
  localparam logic [BCNT_W-1:0] NBITS_C   = BCNT_W'(NBITS);

  logic cur, fall, rise;

  n64_sync u_sync (
    .clk  (clk),
    .rstn (rstn),
    .din  (bus.din),
    .cur  (cur),
    .fall (fall),
    .rise (rise)
  );

  n64_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              serout_q, serout_d;
  logic              shift_en_q, shift_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              bit_val;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    serout_d   = serout_q;
    shift_en_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    bit_val    = (cnt_q < THRESH_C);

    unique case (state_q)
      IDLE: begin
        if (bus.arm) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
          bcnt_d  = '0;
          busy_d  = 1'b1;
        end
      end

      // Waiting for the first falling edge and the high part of a cell share
      // the same inactivity timeout.
      WAIT_LOW, MEAS_HIGH: begin
        if (fall) begin
          state_d = MEAS_LOW;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == IDLE_TO_C) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      MEAS_LOW: begin
        if (rise) begin
          cnt_d = '0;
          if (bcnt_q < NBITS_C) begin
            state_d    = MEAS_HIGH;
            shift_en_d = 1'b1;
            serout_d   = bit_val;
            bcnt_d     = bcnt_q + 1'b1;
          end else begin
            // Stop bit: its value is not checked, it only closes the frame.
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else if (!cur) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == LOW_MAX_C) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      serout_q   <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      serout_q   <= serout_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.serout     = serout_q;
  assign bus.shift_en   = shift_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_n64_bit_decoder.sv
// Directed bench for n64_bit_decoder: frame decode, classification limits,
// timeouts, over-long low pulses and mid-frame reset.
module tb_n64_bit_decoder;

  logic clk;
  logic rstn;

  n64_bit_decoder_if bus ();

  n64_bit_decoder dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Output monitor: cumulative counts plus a shift history of decoded bits.
  int          se_cnt = 0;
  int          fd_cnt = 0;
  int          fe_cnt = 0;
  int          both_cnt = 0;
  logic [63:0] se_bits = '0;

  always @(negedge clk) begin
    if (bus.shift_en) begin
      se_cnt  = se_cnt + 1;
      se_bits = {se_bits[62:0], bus.serout};
    end
    if (bus.frame_done) fd_cnt = fd_cnt + 1;
    if (bus.frame_err) fe_cnt = fe_cnt + 1;
    if (bus.frame_done && bus.frame_err) both_cnt = both_cnt + 1;
  end

  int se0, fd0, fe0;

  task automatic snap();
    se0 = se_cnt;
    fd0 = fd_cnt;
    fe0 = fe_cnt;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  task automatic pulse(input int low, input int high);
    bus.din = 1'b0;
    cycles(low);
    bus.din = 1'b1;
    cycles(high);
  endtask

  // 4 us cell: '1' is 1 us low, '0' is 3 us low.
  task automatic send_bit(input logic b);
    if (b) pulse(50, 150);
    else   pulse(150, 50);
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_stop();
    pulse(50, 150);
  endtask

  initial begin
    rstn    = 1'b0;
    bus.din = 1'b1;
    bus.arm = 1'b0;
    cycles(3);
    chk("rst_busy",     64'(bus.busy),       64'd0);
    chk("rst_shift_en", 64'(bus.shift_en),   64'd0);
    chk("rst_serout",   64'(bus.serout),     64'd0);
    chk("rst_done",     64'(bus.frame_done), 64'd0);
    chk("rst_err",      64'(bus.frame_err),  64'd0);
    rstn = 1'b1;
    cycles(3);

    // Full frame 0x80001234 plus stop bit.
    snap();
    do_arm();
    chk("arm_busy", 64'(bus.busy), 64'd1);
    cycles(20);
    send_word(32'h80001234, 32);
    chk("frame_busy_before_stop", 64'(bus.busy), 64'd1);
    send_stop();
    chk("frame_shifts", 64'(se_cnt - se0), 64'd32);
    chk("frame_bits",   64'(se_bits[31:0]), 64'h80001234);
    chk("frame_done",   64'(fd_cnt - fd0), 64'd1);
    chk("frame_noerr",  64'(fe_cnt - fe0), 64'd0);
    chk("frame_busy_after", 64'(bus.busy), 64'd0);

    // Classification limits: 99 -> '1', 100 -> '0', 249 -> '0', then high timeout.
    snap();
    do_arm();
    cycles(5);
    bus.din = 1'b0;
    cycles(99);
    bus.din = 1'b1;
    cycles(2);
    chk("lat_se_early", 64'(bus.shift_en), 64'd0);
    cycles(1);
    chk("lat_se_3clk", 64'(bus.shift_en), 64'd1);
    chk("lat_serout",  64'(bus.serout),   64'd1);
    cycles(1);
    chk("lat_se_one_cycle", 64'(bus.shift_en), 64'd0);
    cycles(97);
    pulse(100, 100);
    pulse(249, 60);
    chk("bound_shifts", 64'(se_cnt - se0), 64'd3);
    chk("bound_bits",   64'(se_bits[2:0]), 64'b100);
    cycles(320);
    chk("bound_timeout_err", 64'(fe_cnt - fe0), 64'd1);
    chk("bound_no_done",     64'(fd_cnt - fd0), 64'd0);

    // Arm with no line activity: frame_err exactly 300 cycles after accept.
    snap();
    do_arm();
    cycles(299);
    chk("to_err_early", 64'(bus.frame_err), 64'd0);
    chk("to_busy_held", 64'(bus.busy),      64'd1);
    cycles(1);
    chk("to_err_pulse", 64'(bus.frame_err), 64'd1);
    chk("to_busy_drop", 64'(bus.busy),      64'd0);
    cycles(1);
    chk("to_err_one_cycle", 64'(bus.frame_err), 64'd0);
    chk("to_no_shift", 64'(se_cnt - se0), 64'd0);

    // Line held high after bit 10, then a clean frame.
    snap();
    do_arm();
    cycles(10);
    send_word(32'h000002A5, 10);
    cycles(320);
    chk("mid_shifts", 64'(se_cnt - se0), 64'd10);
    chk("mid_bits",   64'(se_bits[9:0]), 64'h2A5);
    chk("mid_err",    64'(fe_cnt - fe0), 64'd1);
    chk("mid_busy",   64'(bus.busy),     64'd0);
    snap();
    do_arm();
    cycles(10);
    send_word(32'hDEADBEEF, 32);
    send_stop();
    chk("re_shifts", 64'(se_cnt - se0), 64'd32);
    chk("re_bits",   64'(se_bits[31:0]), 64'hDEADBEEF);
    chk("re_done",   64'(fd_cnt - fd0), 64'd1);
    chk("re_noerr",  64'(fe_cnt - fe0), 64'd0);

    // Over-long low pulse.
    snap();
    do_arm();
    cycles(10);
    send_word(32'h00000005, 3);
    pulse(260, 10);
    chk("long_shifts", 64'(se_cnt - se0), 64'd3);
    chk("long_err",    64'(fe_cnt - fe0), 64'd1);
    chk("long_busy",   64'(bus.busy),     64'd0);

    // Reset mid-frame, then line activity without arm.
    snap();
    do_arm();
    cycles(10);
    send_word(32'h00000015, 5);
    bus.din = 1'b0;
    cycles(30);
    chk("rstmid_busy_before", 64'(bus.busy), 64'd1);
    rstn = 1'b0;
    #1;
    chk("rstmid_busy",   64'(bus.busy),     64'd0);
    chk("rstmid_serout", 64'(bus.serout),   64'd0);
    cycles(3);
    rstn = 1'b1;
    snap();
    cycles(20);
    bus.din = 1'b1;
    cycles(100);
    send_word(32'h00000006, 3);
    pulse(260, 320);
    chk("noarm_shifts", 64'(se_cnt - se0), 64'd0);
    chk("noarm_done",   64'(fd_cnt - fd0), 64'd0);
    chk("noarm_err",    64'(fe_cnt - fe0), 64'd0);
    chk("noarm_busy",   64'(bus.busy),     64'd0);
    chk("never_both",   64'(both_cnt),     64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
